// File: rtl/cmos_driver_deadtime_ctrl.sv
// Gate-drive sequencer for a pmos/nmos output stage: break-before-make dead time,
// minimum on-time per gate, and a saturating count of handovers.
module cmos_driver_deadtime_ctrl #(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned MIN_ON      = 3,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SW_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in,
    output logic            p_gate_n,
    output logic            n_gate,
    output logic [1:0]      drive_state,
    output logic            busy,
    output logic [SW_W-1:0] sw_cnt
);

    // state | meaning
    // IDLE  | both gates off, output hi-Z
    // LOW   | nmos on, pulling the node to gnd
    // HIGH  | pmos on, pulling the node to vdd
    // DEAD  | both gates off between a pull-up/pull-down handover
    // The encoding doubles as the drive_state output code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOW  = 2'b01,
        ST_HIGH = 2'b10,
        ST_DEAD = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [SW_W-1:0]  SW_MAX    = '1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  on_left, on_left_nxt;
    logic [CNT_W-1:0]  dead_left, dead_left_nxt;
    logic              sw_inc;
    logic              min_met;
    logic              dead_done;
    state_t            level_req;

    assign min_met   = (on_left == '0);
    assign dead_done = (dead_left == '0);
    assign level_req = in ? ST_HIGH : ST_LOW;

    // Down-counters load (length - 1) on entry; terminal count zero means the
    // interval has fully elapsed by the next sampling edge.
    always_comb begin
        state_nxt     = state;
        on_left_nxt   = on_left;
        dead_left_nxt = dead_left;
        sw_inc        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt   = level_req;
                    on_left_nxt = ON_LOAD;
                end
            end
            ST_HIGH, ST_LOW: begin
                if (!en) begin
                    state_nxt   = ST_IDLE;
                    on_left_nxt = '0;
                end else if (level_req != state && min_met) begin
                    state_nxt     = ST_DEAD;
                    on_left_nxt   = '0;
                    dead_left_nxt = DEAD_LOAD;
                    sw_inc        = 1'b1;
                end else if (!min_met) begin
                    on_left_nxt = on_left - CNT_W'(1);
                end
            end
            ST_DEAD: begin
                if (!en) begin
                    state_nxt     = ST_IDLE;
                    dead_left_nxt = '0;
                end else if (dead_done) begin
                    state_nxt   = level_req;
                    on_left_nxt = ON_LOAD;
                end else begin
                    dead_left_nxt = dead_left - CNT_W'(1);
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                on_left_nxt   = '0;
                dead_left_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            on_left   <= '0;
            dead_left <= '0;
        end else begin
            state     <= state_nxt;
            on_left   <= on_left_nxt;
            dead_left <= dead_left_nxt;
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and never pass through a decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_gate_n    <= 1'b1;
            n_gate      <= 1'b0;
            drive_state <= 2'b00;
            busy        <= 1'b0;
        end else begin
            p_gate_n    <= (state_nxt != ST_HIGH);
            n_gate      <= (state_nxt == ST_LOW);
            drive_state <= state_nxt;
            busy        <= (state_nxt == ST_DEAD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cnt <= '0;
        end else if (sw_inc && sw_cnt != SW_MAX) begin
            sw_cnt <= sw_cnt + SW_W'(1);
        end
    end

endmodule

// File: tb/tb_cmos_driver_deadtime_ctrl.sv
// Bench for cmos_driver_deadtime_ctrl: directed sequences then random en/in,
// compared every cycle against a timestamp-based reference model.
module tb_cmos_driver_deadtime_ctrl;

    localparam int DC     = 4;
    localparam int MO     = 3;
    localparam int SWW    = 4;
    localparam int SW_MAX = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           in;
    logic           p_gate_n;
    logic           n_gate;
    logic [1:0]     drive_state;
    logic           busy;
    logic [SWW-1:0] sw_cnt;

    cmos_driver_deadtime_ctrl #(
        .DEAD_CYCLES (DC),
        .MIN_ON      (MO),
        .CNT_W       (8),
        .SW_W        (SWW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in          (in),
        .p_gate_n    (p_gate_n),
        .n_gate      (n_gate),
        .drive_state (drive_state),
        .busy        (busy),
        .sw_cnt      (sw_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: drive mode 0 off, 1 low, 2 high, 3 dead; m_since is the cycle
    // at which the current mode began, so elapsed time is plain subtraction.
    int m_drv, m_since, m_cyc, m_sw;
    logic [1:0] prev_ds;
    int ds_run;

    function automatic void model_reset();
        m_drv   = 0;
        m_since = 0;
        m_cyc   = 0;
        m_sw    = 0;
        prev_ds = 2'b00;
        ds_run  = 0;
    endfunction

    function automatic void model_edge(logic e, logic i);
        int want;
        m_cyc++;
        want = i ? 2 : 1;
        if (!e) begin
            m_drv = 0;
        end else if (m_drv == 0) begin
            m_drv   = want;
            m_since = m_cyc;
        end else if (m_drv == 3) begin
            if (m_cyc - m_since >= DC) begin
                m_drv   = want;
                m_since = m_cyc;
            end
        end else if (want != m_drv && m_cyc - m_since >= MO) begin
            m_drv   = 3;
            m_since = m_cyc;
            if (m_sw < SW_MAX) m_sw++;
        end
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        logic [1:0] ds_exp;
        ds_exp = (m_drv == 0) ? 2'b00 : (m_drv == 1) ? 2'b01 : (m_drv == 2) ? 2'b10 : 2'b11;
        chk({tag, ".p_gate_n"}, 16'(p_gate_n), 16'(m_drv != 2));
        chk({tag, ".n_gate"}, 16'(n_gate), 16'(m_drv == 1));
        chk({tag, ".drive_state"}, 16'(drive_state), 16'(ds_exp));
        chk({tag, ".busy"}, 16'(busy), 16'(m_drv == 3));
        chk({tag, ".sw_cnt"}, 16'(sw_cnt), 16'(m_sw));
        chk({tag, ".shoot_through"}, 16'(!p_gate_n && n_gate), 16'd0);
    endtask

    // Independent run-length checks on the observed drive_state sequence.
    task automatic run_checks();
        if (drive_state != prev_ds) begin
            if (drive_state == 2'b11 && (prev_ds == 2'b01 || prev_ds == 2'b10))
                chk("min_on_len", (ds_run >= MO) ? 16'd1 : 16'd0, 16'd1);
            if (prev_ds == 2'b11 && drive_state != 2'b00)
                chk("dead_len", 16'(ds_run), 16'(DC));
            ds_run = 1;
        end else begin
            ds_run++;
        end
        prev_ds = drive_state;
    endtask

    task automatic step(logic e, logic i, string tag);
        @(negedge clk);
        en = e;
        in = i;
        @(posedge clk);
        model_edge(e, i);
        #1;
        check_model(tag);
        run_checks();
    endtask

    initial begin
        logic cur_in;
        rst = 1'b1;
        en  = 1'b0;
        in  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.p_gate_n", 16'(p_gate_n), 16'd1);
        chk("reset.n_gate", 16'(n_gate), 16'd0);
        chk("reset.drive_state", 16'(drive_state), 16'd0);
        chk("reset.busy", 16'(busy), 16'd0);
        chk("reset.sw_cnt", 16'(sw_cnt), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Startup straight into HIGH, no dead time from IDLE
        step(1'b1, 1'b1, "startup");
        chk("startup.pgn_on", 16'(p_gate_n), 16'd0);
        chk("startup.ds_high", 16'(drive_state), 16'd2);
        step(1'b1, 1'b1, "hold_high");
        step(1'b1, 1'b1, "hold_high");

        // HIGH -> LOW handover
        step(1'b1, 1'b0, "handover_k");
        chk("handover.busy", 16'(busy), 16'd1);
        chk("handover.pgn_off", 16'(p_gate_n), 16'd1);
        repeat (DC - 1) step(1'b1, 1'b0, "handover_dead");
        step(1'b1, 1'b0, "handover_k4");
        chk("handover.n_on", 16'(n_gate), 16'd1);
        chk("handover.ds_low", 16'(drive_state), 16'd1);
        chk("handover.sw1", 16'(sw_cnt), 16'd1);

        // Request HIGH before MIN_ON is met in LOW: must hold LOW first
        step(1'b1, 1'b1, "early_req");
        chk("early_req.still_low", 16'(drive_state), 16'd1);
        step(1'b1, 1'b1, "early_req");
        step(1'b1, 1'b1, "to_dead");
        repeat (DC) step(1'b1, 1'b1, "to_high");
        chk("to_high.ds", 16'(drive_state), 16'd2);
        step(1'b1, 1'b1, "hold_high");
        step(1'b1, 1'b1, "hold_high");

        // One-cycle glitch to 0 after MIN_ON: full dead time, back to HIGH
        step(1'b1, 1'b0, "glitch");
        repeat (DC) step(1'b1, 1'b1, "glitch_dead");
        chk("glitch.ds_high", 16'(drive_state), 16'd2);
        chk("glitch.sw3", 16'(sw_cnt), 16'd3);

        // Toggle every cycle
        for (int t = 0; t < 40; t++) step(1'b1, t[0], "toggle");

        // Release during dead time
        repeat (8) step(1'b1, 1'b1, "settle_high");
        step(1'b1, 1'b0, "rel_dead1");
        step(1'b1, 1'b0, "rel_dead2");
        step(1'b0, 1'b0, "release");
        chk("release.ds", 16'(drive_state), 16'd0);
        chk("release.busy", 16'(busy), 16'd0);
        step(1'b1, 1'b1, "reenable");
        chk("reenable.ds_high", 16'(drive_state), 16'd2);
        step(1'b1, 1'b1, "hold_high");

        // Asynchronous reset between edges while driving high
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.p_gate_n", 16'(p_gate_n), 16'd1);
        chk("async_rst.n_gate", 16'(n_gate), 16'd0);
        chk("async_rst.drive_state", 16'(drive_state), 16'd0);
        chk("async_rst.sw_cnt", 16'(sw_cnt), 16'd0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, "post_rst_idle");
        step(1'b0, 1'b0, "post_rst_idle");
        chk("post_rst.ds_idle", 16'(drive_state), 16'd0);

        // Saturation of the handover counter
        step(1'b1, 1'b1, "sat_start");
        repeat (3) step(1'b1, 1'b1, "sat_start");
        for (int h = 0; h < 20; h++) begin
            cur_in = h[0];
            repeat (8) step(1'b1, cur_in, "sat");
        end
        chk("sat.sw_max", 16'(sw_cnt), 16'(SW_MAX));

        // Random en/in
        en = 1'b1;
        cur_in = 1'b0;
        for (int r = 0; r < 10000; r++) begin
            logic e;
            e = ($urandom_range(0, 19) != 0);
            if (r % 2000 < 1000) begin
                if ($urandom_range(0, 3) == 0) cur_in = ~cur_in;
            end else begin
                cur_in = 1'($urandom_range(0, 1));
            end
            step(e, cur_in, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmos_driver_deadtime_ctrl.md
Name: cmos_driver_deadtime_ctrl

Overview:
Clocked gate-drive controller for a switch-level CMOS output stage: a pmos pull-up to vdd and an nmos pull-down to gnd on a shared output node. It sequences the two gate controls from a requested logic level and enforces break-before-make dead time. It also enforces a minimum on-time, so pmos and nmos never conduct together (no shoot-through) and the stage never chatters. It sits between digital control logic and the switch-level driver instance.

Parameters:
DEAD_CYCLES, 4, clock cycles with both transistors off between any pull-up/pull-down handover; legal range 1..255.
MIN_ON, 3, minimum consecutive cycles a gate stays on once asserted; legal range 1..255.
CNT_W, 8, width of internal dead and on-time counters; must hold max(DEAD_CYCLES, MIN_ON).
SW_W, 16, width of the switch-event counter.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  1 = drive output; 0 = release to hi-Z (both off).
in  input  1  requested output level (1 = pull up, 0 = pull down).
p_gate_n  output  1  pmos gate; 0 = pmos on.
n_gate  output  1  nmos gate; 1 = nmos on.
drive_state  output  2  00 hi-Z, 01 driving low, 10 driving high, 11 dead time.
busy  output  1  1 while in dead time.
sw_cnt  output  SW_W  count of handovers started; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-safe deassert): p_gate_n=1, n_gate=0, drive_state=00, busy=0, sw_cnt=0, counters=0, FSM=IDLE. Outputs take reset values immediately, without a clock edge.
- All outputs are registered; en and in are sampled on rising clk.
- FSM states:
  - IDLE: both off. If en=1, go next edge to HIGH if in=1, else LOW. There is no dead time from IDLE, because both gates are already off.
  - HIGH: p_gate_n=0, n_gate=0. on_cnt counts cycles in state.
    - en=0: go to IDLE next edge; pmos off immediately.
    - in=0 and MIN_ON cycles elapsed: go to DEAD; pmos off at that edge; sw_cnt+1.
    - in=0 before MIN_ON elapsed: stay in HIGH until MIN_ON is met. The request is re-evaluated each cycle, not latched.
  - LOW: mirror of HIGH with n_gate=1, p_gate_n=1.
  - DEAD: both off, busy=1, drive_state=11; dead counter runs DEAD_CYCLES cycles.
    - en=0: go to IDLE next edge; counter cleared.
    - At expiry: sample in. in=1 goes to HIGH, in=0 goes to LOW. Both gates are therefore off for exactly DEAD_CYCLES clock periods.
    - A return to the original level during DEAD still completes the full dead time. That handover counts in sw_cnt.
- Latency, HIGH to LOW with MIN_ON met:
  - in=0 sampled at edge k: p_gate_n=1 after edge k.
  - n_gate=1 after edge k+DEAD_CYCLES.
  - LOW to HIGH is symmetric.
- On entry to HIGH or LOW, on_cnt restarts at 1 for that cycle.
- Invariant, every cycle including reset and en toggling: never (p_gate_n==0 && n_gate==1).
- Gate transitions:
  - Turn-off is always immediate (next edge).
  - Turn-on happens only from IDLE, or after a full dead time.
- sw_cnt:
  - Increments only on HIGH-to-DEAD or LOW-to-DEAD.
  - Holds at 2^SW_W-1.
  - Cleared only by rst.
- en=0 has priority over all in activity in every state.

Test Plan:
- Reset mid-drive: reach HIGH (p_gate_n=0), assert rst between clock edges → p_gate_n=1, n_gate=0, drive_state=00, sw_cnt=0 before the next edge. Hold rst 3 cycles, release → stays IDLE while en=0.
- Startup: DEAD_CYCLES=4, MIN_ON=3; en=1, in=1 at edge 0 → p_gate_n=0, drive_state=10 after edge 0; n_gate remains 0.
- Handover: in HIGH ≥3 cycles, in=0 at edge k → p_gate_n=1, busy=1 after k. Both gates off after k..k+3. n_gate=1, drive_state=01 after edge k+4. sw_cnt=1.
- Min-on and glitch:
  - in toggles every cycle with en=1 → each gate's asserted pulses last ≥3 cycles; separating off-gaps are exactly 4 cycles.
  - Separately: in 1→0 for 1 cycle after MIN_ON, back to 1 → 4 dead cycles, then HIGH again, sw_cnt+1.
- Release during dead: en=0 at dead cycle 2 → drive_state=00, busy=0 next edge. Re-enable with in=1 → HIGH next edge.
- Randomized en/in for 10k cycles with a shoot-through assertion and a dead-time-length checker. Force sw_cnt near saturation (SW_W=4, 20 handovers) → holds at 15.
